fix_calc_alu: RTL and testbench
===============================

Name: fix_calc_alu

Overview:
- Downstream consumer of the decimal-to-fixed-point converter. It takes the converter's Q4.8 word (`digit`) and its repeating `complete` strobe.
- Latches converted values as operands A and B. Runs add/sub (single cycle) or a sequential shift-add multiply on them.
- Presents a Q4.8 result with overflow/negative flags to the display stage.

Parameters:
- W_INT, 4, integer bits of the operand/result.
- W_FRAC, 8, fraction bits of the operand/result.
- Derived, not overridable: W = W_INT + W_FRAC (12).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- digit  in  W  converter output, Q4.8 unsigned.
- complete  in  1  converter valid strobe; level, high for several consecutive cycles per conversion.
- load_a  in  1  copy latched input into operand A.
- load_b  in  1  copy latched input into operand B.
- op  in  2  0=ADD, 1=SUB (A-B), 2=MUL, 3=DIV (see Optional Feature).
- go  in  1  start operation, single-cycle pulse.
- in_val  out  W  most recently captured digit.
- result  out  W  Q4.8 result magnitude.
- ovf  out  1  result overflow / error.
- neg  out  1  SUB result negative.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous, any state including mid-operation:
  - state=IDLE.
  - A, B, in_val, result = 0.
  - ovf, neg, busy, done = 0.
  - Edge-detect register = 0.
  - Multiply/divide accumulators and iteration count cleared.
- Input capture:
  - complete is registered (complete_d).
  - On an edge where complete=1 and complete_d=0, in_val <= digit.
  - A multi-cycle complete level causes exactly one capture.
  - Capture is independent of state.
- Operand load, IDLE only:
  - load_a: A <= in_val. load_b: B <= in_val. Both asserted: both load.
  - Loads while busy are ignored.
  - Load has priority over go: if a load and go occur in the same cycle, go is ignored.
- FSM states: IDLE, ALU, MUL, DIV, DONE.
  - IDLE: go=1 and no load goes to ALU (op 0/1), MUL (op 2), or DIV (op 3). go is ignored in any other state.
  - ALU: one cycle, then DONE.
    - ADD: 13-bit sum; result = sum[W-1:0]; ovf = sum[W]; neg = 0.
    - SUB: if A>=B then result = A-B, neg=0; else result = B-A, neg=1. ovf = 0.
  - MUL: W iterations, one per cycle, LSB-first shift-add over B.
    - Produces a 2W-bit product P.
    - On the last iteration go to DONE with result = P[W+W_FRAC-1:W_FRAC] (truncation, no rounding).
    - ovf = |P[2W-1:W+W_FRAC]; neg = 0.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Outputs:
  - result, ovf and neg update only on the edge entering DONE and hold until the next operation completes.
  - busy=1 in ALU, MUL, DIV and DONE.
- Latency, counted from the edge sampling go to the edge raising done:
  - ADD/SUB: 1.
  - MUL: W (12).
  - DIV: W+W_FRAC (20).
- op and operands are sampled at go; changes during busy have no effect.

Optional Feature:
- Macro FIX_CALC_DIV_EN.
- Defined: op=3 runs restoring division over W+W_FRAC iterations.
  - Dividend is A<<W_FRAC; quotient Q is (W+W_FRAC) bits.
  - result = Q[W-1:0]; ovf = |Q[W+W_FRAC-1:W]; neg=0.
  - B=0: skip iterations and go to DONE on the next edge with result=all-ones (0xFFF) and ovf=1.
- Undefined: op=3 goes to ALU and completes with latency 1, result=0, ovf=1, neg=0. The DIV state and its datapath are absent.

Decomposition:
- Shared package `fix_calc_pkg`:
  - W_INT/W_FRAC defaults.
  - op encoding constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - FSM state encoding.
  - Q4.8 helper constants (ONE = 0x100, MAX = 0xFFF).
- One sub-module, `fix_seq_core`: the iterative shift-add multiplier plus restoring divider. It has start/done, a shared iteration counter and an accumulator. The top holds capture, operand registers, the ALU and the FSM.

Test Plan:
- Capture: complete high 5 cycles with digit=0x380 -> in_val=0x380 after the first edge, exactly one update; complete low then high with 0x240 -> in_val=0x240.
- ADD: A=0x380 (3.5), B=0x240 (2.25), op=0, go -> done 1 edge later, result=0x5C0, ovf=0; then A=0x980, B=0x800 -> result=0x180, ovf=1.
- SUB: A=0x380, B=0x240 -> result=0x140, neg=0; swapped (A=0x240, B=0x380) -> result=0x140, neg=1.
- MUL: A=0x380, B=0x240 -> done 12 edges after go, result=0x7E0, ovf=0; A=B=0x400 -> result=0x000, ovf=1; go pulsed during busy -> ignored, no second done.
- DIV (with macro): A=0x7E0, B=0x240 -> result=0x380 at 20 edges; B=0 -> result=0xFFF, ovf=1 after 1 edge. Without macro: op=3 -> result=0, ovf=1, latency 1.
- Reset mid-MUL (cycle 6): RST pulse -> all outputs 0 immediately, state IDLE, no done; a subsequent go runs normally with A=B=0 -> result=0.

Source files
------------

// File: rtl/fix_calc_pkg.sv
// Shared definitions for the Q4.8 calculator: widths, op codes, FSM states, fixed-point constants.
package fix_calc_pkg;

    localparam int FIX_W_INT  = 4;
    localparam int FIX_W_FRAC = 8;
    localparam int FIX_W      = FIX_W_INT + FIX_W_FRAC;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [FIX_W-1:0] Q_ONE = 12'h100;
    localparam logic [FIX_W-1:0] Q_MAX = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ALU  = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/fix_seq_core.sv
// Iterative engine: LSB-first shift-add multiply (W steps) and, with FIX_CALC_DIV_EN, restoring divide (W+W_FRAC steps).
// o_last is high during the final step; the o_*_res/o_*_ovf outputs show the value that step produces.
module fix_seq_core
    import fix_calc_pkg::*;
#(
    parameter int W_INT  = FIX_W_INT,
    parameter int W_FRAC = FIX_W_FRAC
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
`ifdef FIX_CALC_DIV_EN
    input  logic                      i_div,
`endif
    input  logic [W_INT+W_FRAC-1:0]   i_a,
    input  logic [W_INT+W_FRAC-1:0]   i_b,
    output logic                      o_last,
    output logic [W_INT+W_FRAC-1:0]   o_mul_res,
`ifdef FIX_CALC_DIV_EN
    output logic [W_INT+W_FRAC-1:0]   o_div_res,
    output logic                      o_div_ovf,
`endif
    output logic                      o_mul_ovf
);

    localparam int W = W_INT + W_FRAC;
`ifdef FIX_CALC_DIV_EN
    localparam int ACC_W = 2 * W + W_FRAC;
    localparam int N_MAX = W + W_FRAC;
`else
    localparam int ACC_W = 2 * W;
    localparam int N_MAX = W;
`endif
    localparam int CNT_W = $clog2(N_MAX);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [W-1:0]     r_opd;
    logic [W:0]       w_mul_sum;
    logic [2*W-1:0]   w_mul_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_last_cnt;

    // Multiply: acc = {hi, multiplier}; add multiplicand into hi when the shifted-out bit is set.
    assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opd} : {(W+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[W-1:1]};

`ifdef FIX_CALC_DIV_EN
    logic             r_div;
    logic [W:0]       w_rsh;
    logic             w_ge;
    logic [W-1:0]     w_rdiff;
    logic [ACC_W-1:0] w_div_nxt;

    // Divide: acc = {remainder, dividend/quotient}; remainder stays below the divisor, so W bits suffice.
    assign w_rsh     = r_acc[ACC_W-1:W+W_FRAC-1];
    assign w_ge      = (w_rsh >= {1'b0, r_opd});
    assign w_rdiff   = w_rsh[W-1:0] - r_opd;
    assign w_div_nxt = {(w_ge ? w_rdiff : w_rsh[W-1:0]), r_acc[W+W_FRAC-2:0], w_ge};
    assign w_acc_nxt = r_div ? w_div_nxt : {{W_FRAC{1'b0}}, w_mul_nxt};
    assign w_last_cnt = r_div ? CNT_W'(W + W_FRAC - 1) : CNT_W'(W - 1);
    assign o_div_res = w_div_nxt[W-1:0];
    assign o_div_ovf = |w_div_nxt[W+W_FRAC-1:W];
`else
    assign w_acc_nxt  = w_mul_nxt;
    assign w_last_cnt = CNT_W'(W - 1);
`endif

    assign o_last    = r_busy && (r_cnt == w_last_cnt);
    assign o_mul_res = w_mul_nxt[W+W_FRAC-1:W_FRAC];
    assign o_mul_ovf = |w_mul_nxt[2*W-1:W+W_FRAC];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_opd  <= '0;
`ifdef FIX_CALC_DIV_EN
            r_div  <= 1'b0;
`endif
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
`ifdef FIX_CALC_DIV_EN
            r_div  <= i_div;
            if (i_div) begin
                r_acc <= {{W{1'b0}}, i_a, {W_FRAC{1'b0}}};
                r_opd <= i_b;
            end else begin
                r_acc <= {{(ACC_W-W){1'b0}}, i_b};
                r_opd <= i_a;
            end
`else
            r_acc  <= {{(ACC_W-W){1'b0}}, i_b};
            r_opd  <= i_a;
`endif
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (o_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fix_calc_alu.sv
// Q4.8 calculator behind the decimal converter: edge-captures digits, holds operands A/B, runs ADD/SUB/MUL(/DIV).
// Latency go->done: ADD/SUB 1, MUL W, DIV W+W_FRAC (op 3 only with FIX_CALC_DIV_EN, else error result in 1).
module fix_calc_alu
    import fix_calc_pkg::*;
#(
    parameter int W_INT  = FIX_W_INT,
    parameter int W_FRAC = FIX_W_FRAC
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [W_INT+W_FRAC-1:0] digit,
    input  logic                    complete,
    input  logic                    load_a,
    input  logic                    load_b,
    input  logic [1:0]              op,
    input  logic                    go,
    output logic [W_INT+W_FRAC-1:0] in_val,
    output logic [W_INT+W_FRAC-1:0] result,
    output logic                    ovf,
    output logic                    neg,
    output logic                    busy,
    output logic                    done
);

    localparam int W = W_INT + W_FRAC;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_cmp_d;
    logic [W-1:0] r_in_val;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [1:0]   r_op;
    logic [W-1:0] r_result;
    logic         r_ovf;
    logic         r_neg;

    logic         w_accept;
    logic         w_core_start;
    logic         w_upd;
    logic [W-1:0] w_res_nxt;
    logic         w_ovf_nxt;
    logic         w_neg_nxt;
    logic [W:0]   w_sum;
    logic         w_core_last;
    logic [W-1:0] w_mul_res;
    logic         w_mul_ovf;

    assign w_accept = (r_state == ST_IDLE) && go && !load_a && !load_b;
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};

`ifdef FIX_CALC_DIV_EN
    logic [W-1:0] w_div_res;
    logic         w_div_ovf;
`endif

    fix_seq_core #(
        .W_INT  (W_INT),
        .W_FRAC (W_FRAC)
    ) u_seq (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_start   (w_core_start),
`ifdef FIX_CALC_DIV_EN
        .i_div     (op == OP_DIV),
        .o_div_res (w_div_res),
        .o_div_ovf (w_div_ovf),
`endif
        .i_a       (r_a),
        .i_b       (r_b),
        .o_last    (w_core_last),
        .o_mul_res (w_mul_res),
        .o_mul_ovf (w_mul_ovf)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_core_start = 1'b0;
        w_upd        = 1'b0;
        w_res_nxt    = r_result;
        w_ovf_nxt    = r_ovf;
        w_neg_nxt    = r_neg;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (op)
                        OP_MUL: begin
                            w_state_nxt  = ST_MUL;
                            w_core_start = 1'b1;
                        end
`ifdef FIX_CALC_DIV_EN
                        OP_DIV: begin
                            w_state_nxt  = ST_DIV;
                            w_core_start = (r_b != '0);
                        end
`endif
                        default: w_state_nxt = ST_ALU;
                    endcase
                end
            end
            ST_ALU: begin
                w_state_nxt = ST_DONE;
                w_upd       = 1'b1;
                w_neg_nxt   = 1'b0;
                w_ovf_nxt   = 1'b0;
                case (r_op)
                    OP_ADD: begin
                        w_res_nxt = w_sum[W-1:0];
                        w_ovf_nxt = w_sum[W];
                    end
                    OP_SUB: begin
                        if (r_a >= r_b) begin
                            w_res_nxt = r_a - r_b;
                        end else begin
                            w_res_nxt = r_b - r_a;
                            w_neg_nxt = 1'b1;
                        end
                    end
                    // Only op 3 without the divider lands here: flag it as an error.
                    default: begin
                        w_res_nxt = '0;
                        w_ovf_nxt = 1'b1;
                    end
                endcase
            end
            ST_MUL: begin
                if (w_core_last) begin
                    w_state_nxt = ST_DONE;
                    w_upd       = 1'b1;
                    w_res_nxt   = w_mul_res;
                    w_ovf_nxt   = w_mul_ovf;
                    w_neg_nxt   = 1'b0;
                end
            end
`ifdef FIX_CALC_DIV_EN
            ST_DIV: begin
                if (r_b == '0) begin
                    w_state_nxt = ST_DONE;
                    w_upd       = 1'b1;
                    w_res_nxt   = '1;
                    w_ovf_nxt   = 1'b1;
                    w_neg_nxt   = 1'b0;
                end else if (w_core_last) begin
                    w_state_nxt = ST_DONE;
                    w_upd       = 1'b1;
                    w_res_nxt   = w_div_res;
                    w_ovf_nxt   = w_div_ovf;
                    w_neg_nxt   = 1'b0;
                end
            end
`endif
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_cmp_d  <= 1'b0;
            r_in_val <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cmp_d <= complete;
            if (complete && !r_cmp_d) begin
                r_in_val <= digit;
            end
            if (r_state == ST_IDLE) begin
                if (load_a) begin
                    r_a <= r_in_val;
                end
                if (load_b) begin
                    r_b <= r_in_val;
                end
            end
            if (w_accept) begin
                r_op <= op;
            end
            if (w_upd) begin
                r_result <= w_res_nxt;
                r_ovf    <= w_ovf_nxt;
                r_neg    <= w_neg_nxt;
            end
        end
    end

    assign in_val = r_in_val;
    assign result = r_result;
    assign ovf    = r_ovf;
    assign neg    = r_neg;
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_fix_calc_alu.sv
// Randomized and directed bench for fix_calc_alu against an arithmetic reference model.
module tb_fix_calc_alu;
    import fix_calc_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [11:0] digit;
    logic        complete;
    logic        load_a;
    logic        load_b;
    logic [1:0]  op;
    logic        go;
    logic [11:0] in_val;
    logic [11:0] result;
    logic        ovf;
    logic        neg;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;
    int m_a   = 0;
    int m_b   = 0;

    fix_calc_alu dut (
        .CLK      (CLK),
        .RST      (RST),
        .digit    (digit),
        .complete (complete),
        .load_a   (load_a),
        .load_b   (load_b),
        .op       (op),
        .go       (go),
        .in_val   (in_val),
        .result   (result),
        .ovf      (ovf),
        .neg      (neg),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: plain integer arithmetic on Q4.8 values (scale 256).
    function automatic void model(input logic [1:0] o, input int a, input int b,
                                  output int r, output int v, output int n, output int lat);
        int s;
        r = 0; v = 0; n = 0; lat = 1; s = 0;
        case (o)
            2'd0: begin
                s = a + b;
                r = s % 4096;
                v = (s > 4095) ? 1 : 0;
            end
            2'd1: begin
                if (a >= b) r = a - b;
                else begin r = b - a; n = 1; end
            end
            2'd2: begin
                s = a * b;
                r = (s / 256) % 4096;
                v = ((s / 1048576) != 0) ? 1 : 0;
                lat = 12;
            end
            default: begin
`ifdef FIX_CALC_DIV_EN
                if (b == 0) begin
                    r = 4095; v = 1;
                end else begin
                    s = (a * 256) / b;
                    r = s % 4096;
                    v = ((s / 4096) != 0) ? 1 : 0;
                    lat = 20;
                end
`else
                r = 0; v = 1;
`endif
            end
        endcase
    endfunction

    task automatic capture(input logic [11:0] v);
        digit    = v;
        complete = 1'b1;
        tick();
        complete = 1'b0;
        check("capture", in_val, v);
        tick();
    endtask

    task automatic load(input int a, input int b);
        capture(12'(a));
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        capture(12'(b));
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
        m_a = a;
        m_b = b;
    endtask

    task automatic run_op(input logic [1:0] o, input string tag);
        int er, ev, en, el, k;
        model(o, m_a, m_b, er, ev, en, el);
        op = o;
        go = 1'b1;
        tick();
        go = 1'b0;
        op = 2'($urandom);
        check($sformatf("%s_busy", tag), busy, 1);
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        check($sformatf("%s_lat", tag), k, el);
        check($sformatf("%s_res", tag), result, er);
        check($sformatf("%s_ovf", tag), ovf, ev);
        check($sformatf("%s_neg", tag), neg, en);
        tick();
        check($sformatf("%s_pulse", tag), {busy, done}, 0);
        check($sformatf("%s_hold", tag), result, er);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nd;
        RST = 1'b1; digit = '0; complete = 1'b0; load_a = 1'b0; load_b = 1'b0;
        op = OP_ADD; go = 1'b0;
        repeat (3) tick();
        check("rst_outs", {in_val, result, ovf, neg, busy, done}, 0);
        RST = 1'b0;
        tick();

        // Capture: one update per complete level, regardless of its length.
        digit = 12'h380; complete = 1'b1;
        tick();
        check("cap_first", in_val, 12'h380);
        digit = 12'h111;
        repeat (4) tick();
        check("cap_once", in_val, 12'h380);
        complete = 1'b0;
        tick();
        digit = 12'h240; complete = 1'b1;
        tick();
        check("cap_second", in_val, 12'h240);
        complete = 1'b0;
        tick();

        load(12'h380, 12'h240); run_op(OP_ADD, "add");
        load(12'h980, 12'h800); run_op(OP_ADD, "add_ovf");
        load(12'h380, 12'h240); run_op(OP_SUB, "sub");
        load(12'h240, 12'h380); run_op(OP_SUB, "sub_neg");
        load(12'h380, 12'h240); run_op(OP_MUL, "mul");
        load(12'h400, 12'h400); run_op(OP_MUL, "mul_ovf");
        load(12'h7E0, 12'h240); run_op(OP_DIV, "div");
        load(12'h7E0, 12'h000); run_op(OP_DIV, "div_zero");

        // Load and go together: go is dropped.
        load(12'h100, 12'h200);
        capture(12'h050);
        load_a = 1'b1; go = 1'b1; op = OP_ADD;
        tick();
        load_a = 1'b0; go = 1'b0;
        m_a = 12'h050;
        tick();
        check("load_go_idle", {busy, done}, 0);
        run_op(OP_ADD, "add_after_load");

        // MUL with a stray go and a load attempt while busy.
        load(12'h380, 12'h240);
        op = OP_MUL; go = 1'b1;
        tick();
        go = 1'b0; k = 0;
        tick(); k++;
        tick(); k++;
        go = 1'b1;
        tick(); k++;
        go = 1'b0;
        capture(12'h123); k += 2;
        load_a = 1'b1;
        tick(); k++;
        load_a = 1'b0;
        while (!done && k < 40) begin tick(); k++; end
        check("mul_busy_lat", k, 12);
        check("mul_busy_res", result, 12'h7E0);
        nd = 0;
        repeat (20) begin tick(); if (done) nd++; end
        check("mul_no_second_done", nd, 0);
        run_op(OP_ADD, "add_a_kept");

        // Asynchronous reset in the middle of a multiply.
        load(12'h380, 12'h240);
        op = OP_MUL; go = 1'b1;
        tick();
        go = 1'b0;
        repeat (6) tick();
        RST = 1'b1;
        #1;
        check("rst_mid_outs", {in_val, result, ovf, neg, busy, done}, 0);
        tick();
        RST = 1'b0;
        m_a = 0; m_b = 0;
        nd = 0;
        repeat (14) begin tick(); if (done || busy) nd++; end
        check("rst_mid_quiet", nd, 0);
        run_op(OP_MUL, "mul_after_rst");

        repeat (30) begin
            int a, b;
            logic [1:0] o;
            a = $urandom_range(0, 4095);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 4095);
            o = 2'($urandom_range(0, 3));
            load(a, b);
            run_op(o, $sformatf("rnd_op%0d", o));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
